// File: rtl/vga_timing_core.sv
// VGA timing core: clock-enable dividers, 640x480@60 timing counters,
// registered sync decode and an 8-bar colour test pattern on 4-bit RGB.
module vga_timing_core #(
  parameter int unsigned PIX_DIV  = 4,
  parameter int unsigned CNT_DIV  = 20,
  parameter int unsigned UART_DIV = 54,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_ce,
  output logic       counter_ce,
  output logic       uart_ce,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b
);

  localparam int unsigned PIX_W  = (PIX_DIV  > 1) ? $clog2(PIX_DIV)  : 1;
  localparam int unsigned CNT_W  = (CNT_DIV  > 1) ? $clog2(CNT_DIV)  : 1;
  localparam int unsigned UART_W = (UART_DIV > 1) ? $clog2(UART_DIV) : 1;

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam int unsigned BAR_W   = H_ACTIVE / 8;

  logic [PIX_W-1:0]  pix_cnt_q,  pix_cnt_d;
  logic [CNT_W-1:0]  cnt_cnt_q,  cnt_cnt_d;
  logic [UART_W-1:0] uart_cnt_q, uart_cnt_d;
  logic [9:0]        h_q, h_d, v_q, v_d;
  logic              hs_q, hs_d, vs_q, vs_d;
  logic [3:0]        r_q, r_d, g_q, g_d, b_q, b_d;
  logic [2:0]        bar;
  logic              active;

  assign pix_ce     = (pix_cnt_q  == PIX_W'(PIX_DIV - 1));
  assign counter_ce = (cnt_cnt_q  == CNT_W'(CNT_DIV - 1));
  assign uart_ce    = (uart_cnt_q == UART_W'(UART_DIV - 1));

  always_comb begin
    pix_cnt_d  = pix_ce     ? '0 : pix_cnt_q  + 1'b1;
    cnt_cnt_d  = counter_ce ? '0 : cnt_cnt_q  + 1'b1;
    uart_cnt_d = uart_ce    ? '0 : uart_cnt_q + 1'b1;
  end

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_ce) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Bar index by threshold compare rather than a divide by BAR_W.
  always_comb begin
    bar = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (h_q >= 10'(i * BAR_W)) bar = 3'(i);
    end
  end

  // Bar colour bits: red off for bars 2,3,6,7; green off for 4..7; blue off for odd bars.
  always_comb begin
    active = (h_q < H_ACT) && (v_q < V_ACT);
    hs_d   = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    vs_d   = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    r_d    = (active && !bar[1]) ? '1 : '0;
    g_d    = (active && !bar[2]) ? '1 : '0;
    b_d    = (active && !bar[0]) ? '1 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt_q  <= '0;
      cnt_cnt_q  <= '0;
      uart_cnt_q <= '0;
      h_q        <= '0;
      v_q        <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
    end else begin
      pix_cnt_q  <= pix_cnt_d;
      cnt_cnt_q  <= cnt_cnt_d;
      uart_cnt_q <= uart_cnt_d;
      h_q        <= h_d;
      v_q        <= v_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
    end
  end

  assign h_count = h_q;
  assign v_count = v_q;
  assign vga_hs  = hs_q;
  assign vga_vs  = vs_q;
  assign vga_r   = r_q;
  assign vga_g   = g_q;
  assign vga_b   = b_q;

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core. Vertical timing is shrunk (6-line frame) so whole
// frames fit a short run; horizontal timing and all dividers keep their real values.
module tb_vga_timing_core;

  localparam int VA = 2, VF = 1, VS = 2, VB = 1;
  localparam int V_TOT = VA + VF + VS + VB;
  localparam int LINE_CLKS  = 800 * 4;
  localparam int FRAME_CLKS = V_TOT * LINE_CLKS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_ce, counter_ce, uart_ce;
  logic [9:0] h_count, v_count;
  logic       vga_hs, vga_vs;
  logic [3:0] vga_r, vga_g, vga_b;

  int n = 0;
  int checks = 0;
  int errors = 0;

  logic [11:0] bars [8];

  vga_timing_core #(
    .PIX_DIV(4), .CNT_DIV(20), .UART_DIV(54),
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst),
    .pix_ce(pix_ce), .counter_ce(counter_ce), .uart_ce(uart_ce),
    .h_count(h_count), .v_count(v_count),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  // {h, v, hs, vs, r, g, b, pix_ce, counter_ce, uart_ce}
  function automatic logic [36:0] observed();
    return {h_count, v_count, vga_hs, vga_vs, vga_r, vga_g, vga_b,
            pix_ce, counter_ce, uart_ce};
  endfunction

  // Expected outputs n clk edges after reset release, from elapsed time alone.
  function automatic logic [36:0] model(input int k);
    int p, q, h, v, qh, qv;
    logic hs, vs;
    logic [11:0] rgb;
    if (k == 0) return {10'd0, 10'd0, 1'b1, 1'b1, 12'h000, 3'b000};
    p  = k / 4;
    h  = p % 800;
    v  = (p / 800) % V_TOT;
    q  = (k - 1) / 4;
    qh = q % 800;
    qv = (q / 800) % V_TOT;
    hs = !(qh >= 656 && qh <= 751);
    vs = !(qv >= VA + VF && qv <= VA + VF + VS - 1);
    rgb = (qh < 640 && qv < VA) ? bars[qh / 80] : 12'h000;
    return {10'(h), 10'(v), hs, vs, rgb,
            (k % 4) == 3, (k % 20) == 19, (k % 54) == 53};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
    n = 0;
  endtask

  task automatic test_reset();
    logic [36:0] rv;
    rv = {10'd0, 10'd0, 1'b1, 1'b1, 12'h000, 3'b000};
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (observed() !== rv) begin
        errors++;
        $display("FAIL reset_state: got %h expected %h", observed(), rv);
      end
    end
    rst = 1'b0;
    n = 0;
    while (pix_ce !== 1'b1 && n < 12) step();
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL first_pix_ce: pix_ce first seen after %0d edges, expected 3", n);
    end
  endtask

  task automatic test_dividers();
    int pc, cc, uc;
    logic pp, pcc, pu;
    pc = 0; cc = 0; uc = 0; pp = 0; pcc = 0; pu = 0;
    do_reset(1 + $urandom_range(0, 3));
    for (int i = 0; i < 1000; i++) begin
      step();
      checks++;
      if (observed() !== model(n)) begin
        errors++;
        $display("FAIL div_outputs n=%0d: got %h expected %h", n, observed(), model(n));
      end
      checks++;
      if ((pp && pix_ce) || (pcc && counter_ce) || (pu && uart_ce)) begin
        errors++;
        $display("FAIL ce_width n=%0d: got %b%b%b after %b%b%b, expected no repeat",
                 n, pix_ce, counter_ce, uart_ce, pp, pcc, pu);
      end
      pc += int'(pix_ce); cc += int'(counter_ce); uc += int'(uart_ce);
      pp = pix_ce; pcc = counter_ce; pu = uart_ce;
    end
    checks++;
    if (pc != 250 || cc != 50 || uc != 18) begin
      errors++;
      $display("FAIL ce_counts: got %0d/%0d/%0d expected 250/50/18", pc, cc, uc);
    end
  endtask

  // Expects reset released with n == 0.
  task automatic test_sync_timing();
    int hs_fall[$], vs_fall[$];
    int hs_run, vs_run, hs_first_run, vs_first_run, vs_fall_v;
    logic phs, pvs;
    logic [9:0] ph;
    phs = 1; pvs = 1; ph = '0;
    hs_run = 0; vs_run = 0; hs_first_run = -1; vs_first_run = -1; vs_fall_v = -1;
    while (vs_fall.size() < 2 && n < 2 * FRAME_CLKS) begin
      step();
      checks++;
      if (observed() !== model(n)) begin
        errors++;
        $display("FAIL sync_outputs n=%0d: got %h expected %h", n, observed(), model(n));
      end
      if (phs && !vga_hs) begin
        hs_fall.push_back(n);
        if (hs_fall.size() == 1) begin
          checks++;
          if (ph !== 10'd656) begin
            errors++;
            $display("FAIL hs_fall_pos: h_count before fall %0d expected 656", ph);
          end
        end
      end
      if (pvs && !vga_vs) begin
        vs_fall.push_back(n);
        if (vs_fall.size() == 1) vs_fall_v = int'(v_count);
      end
      if (!vga_hs) hs_run++;
      else if (!phs && hs_first_run < 0) hs_first_run = hs_run;
      if (!vga_vs) vs_run++;
      else if (!pvs && vs_first_run < 0) vs_first_run = vs_run;
      phs = vga_hs; pvs = vga_vs; ph = h_count;
    end
    checks++;
    if (vs_fall.size() < 2 || hs_fall.size() < 2) begin
      errors++;
      $display("FAIL sync_timeout: got %0d hs / %0d vs falls expected at least 2 each",
               hs_fall.size(), vs_fall.size());
    end else begin
      checks++;
      if (hs_fall[0] != 656 * 4 + 1) begin
        errors++;
        $display("FAIL hs_first_fall: got %0d expected %0d", hs_fall[0], 656 * 4 + 1);
      end
      checks++;
      if (hs_fall[1] - hs_fall[0] != LINE_CLKS) begin
        errors++;
        $display("FAIL hs_period: got %0d expected %0d", hs_fall[1] - hs_fall[0], LINE_CLKS);
      end
      checks++;
      if (hs_first_run != 384) begin
        errors++;
        $display("FAIL hs_width: got %0d expected 384", hs_first_run);
      end
      checks++;
      if (vs_fall_v != VA + VF) begin
        errors++;
        $display("FAIL vs_fall_line: got %0d expected %0d", vs_fall_v, VA + VF);
      end
      checks++;
      if (vs_fall[1] - vs_fall[0] != FRAME_CLKS) begin
        errors++;
        $display("FAIL vs_period: got %0d expected %0d", vs_fall[1] - vs_fall[0], FRAME_CLKS);
      end
      checks++;
      if (vs_first_run != VS * LINE_CLKS) begin
        errors++;
        $display("FAIL vs_width: got %0d expected %0d", vs_first_run, VS * LINE_CLKS);
      end
    end
  endtask

  task automatic test_pattern();
    int spot_n [7];
    logic [11:0] spot_rgb [7];
    int idx;
    spot_n   = '{1, 321, 1601, 2557, 2561, 3201, VA * LINE_CLKS + 1};
    spot_rgb = '{12'hFFF, 12'hFF0, 12'hF00, 12'h000, 12'h000, 12'hFFF, 12'h000};
    idx = 0;
    do_reset(2);
    while (n < VA * LINE_CLKS + 1) begin
      step();
      checks++;
      if (observed() !== model(n)) begin
        errors++;
        $display("FAIL pattern_outputs n=%0d: got %h expected %h", n, observed(), model(n));
      end
      if (idx < 7 && n == spot_n[idx]) begin
        checks++;
        if ({vga_r, vga_g, vga_b} !== spot_rgb[idx]) begin
          errors++;
          $display("FAIL pattern_spot%0d n=%0d: got %h expected %h",
                   idx, n, {vga_r, vga_g, vga_b}, spot_rgb[idx]);
        end
        idx++;
      end
    end
  endtask

  // Continues the frame started by test_pattern.
  task automatic test_mid_reset();
    int target;
    target = ((VA + VF + 1) * 800 + 700) * 4;
    while (n < target) begin
      step();
      checks++;
      if (observed() !== model(n)) begin
        errors++;
        $display("FAIL pre_reset_outputs n=%0d: got %h expected %h", n, observed(), model(n));
      end
    end
    checks++;
    if (vga_hs !== 1'b0 || vga_vs !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_sync: got hs=%b vs=%b expected both 0", vga_hs, vga_vs);
    end
    rst = 1'b1;
    step();
    checks++;
    if (observed() !== {10'd0, 10'd0, 1'b1, 1'b1, 12'h000, 3'b000}) begin
      errors++;
      $display("FAIL mid_reset_state: got %h expected %h", observed(),
               {10'd0, 10'd0, 1'b1, 1'b1, 12'h000, 3'b000});
    end
    rst = 1'b0;
    n = 0;
    test_sync_timing();
  endtask

  initial begin
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    test_reset();
    test_dividers();
    do_reset(3);
    test_sync_timing();
    test_pattern();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
